// File: rtl/adc_trigger_capture.sv
// Trigger capture for the AD9467 sample stream: converts samples to two's complement,
// keeps a pre/post trigger window in a circular buffer and plays it back oldest-first.
module adc_trigger_capture #(
  parameter int AW         = 10,
  parameter bit OFFSET_BIN = 1'b1
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic [15:0]   din,
  input  logic          din_valid,
  input  logic          arm,
  input  logic          abort,
  input  logic          force_trig,
  input  logic [15:0]   trig_level,
  input  logic          trig_edge,
  input  logic [AW:0]   pre_len,
  input  logic [AW:0]   post_len,
  output logic          busy,
  output logic          triggered,
  output logic          done,
  output logic          cfg_err,
  input  logic          rd_req,
  output logic [15:0]   rd_data,
  output logic          rd_valid,
  output logic          rd_last
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ARMED, S_POST, S_DONE, S_READ
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     p_q, p_d, q_q, q_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW+1:0]   rd_idx_q, rd_idx_d;
  logic [15:0]     prev_q, prev_d;
  logic            prev_ok_q, prev_ok_d;
  logic [AW-1:0]   start_q, start_d;
  logic            trig_q, trig_d;
  logic            cfg_err_q, cfg_err_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;
  logic [15:0]     rd_data_q;

  logic [15:0]     mem [DEPTH];

  logic [15:0]     s;
  logic [AW+1:0]   arm_sum, win_len;
  logic            arm_bad, wr_en, rd_accept, rise, fall, trig_hit;
  logic [AW-1:0]   rd_addr;

  assign s        = OFFSET_BIN ? {~din[15], din[14:0]} : din;
  assign arm_sum  = {1'b0, pre_len} + {1'b0, post_len};
  assign arm_bad  = (post_len == '0) || (arm_sum > (AW+2)'(DEPTH));
  assign win_len  = {1'b0, p_q} + {1'b0, q_q};

  assign wr_en     = din_valid && !abort &&
                     (state_q == S_FILL || state_q == S_ARMED || state_q == S_POST);
  assign rd_accept = rd_req && !abort && (state_q == S_DONE || state_q == S_READ) &&
                     (rd_idx_q < win_len);
  assign rd_addr   = start_q + rd_idx_q[AW-1:0];

  assign rise     = ($signed(prev_q) <  $signed(trig_level)) && ($signed(s) >= $signed(trig_level));
  assign fall     = ($signed(prev_q) >= $signed(trig_level)) && ($signed(s) <  $signed(trig_level));
  // With no previous sample (P == 0, first ARMED sample) only force_trig can fire.
  assign trig_hit = din_valid && (force_trig || (prev_ok_q && (trig_edge ? fall : rise)));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    p_d        = p_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    rd_idx_d   = rd_idx_q;
    prev_d     = prev_q;
    prev_ok_d  = prev_ok_q;
    start_d    = start_q;
    trig_d     = trig_q;
    cfg_err_d  = cfg_err_q;
    rd_valid_d = rd_accept;
    rd_last_d  = rd_accept && (rd_idx_q == win_len - (AW+2)'(1));

    if (wr_en) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      prev_d    = s;
      prev_ok_d = 1'b1;
    end
    if (rd_accept) begin
      rd_idx_d = rd_idx_q + 1'b1;
    end

    if (abort) begin
      state_d = S_IDLE;
      trig_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm) begin
            p_d = pre_len;
            q_d = post_len;
            if (arm_bad) begin
              cfg_err_d = 1'b1;
            end else begin
              cfg_err_d = 1'b0;
              trig_d    = 1'b0;
              cnt_d     = '0;
              rd_idx_d  = '0;
              prev_ok_d = 1'b0;
              state_d   = (pre_len == '0) ? S_ARMED : S_FILL;
            end
          end
        end
        S_FILL: begin
          if (din_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == p_q) state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (trig_hit) begin
            start_d = wr_ptr_q - p_q[AW-1:0];
            trig_d  = 1'b1;
            cnt_d   = (AW+1)'(1);
            state_d = (q_q == (AW+1)'(1)) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (din_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == q_q) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (rd_accept) state_d = S_READ;
        end
        S_READ: begin
          if (rd_last_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      p_q        <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      rd_idx_q   <= '0;
      prev_q     <= '0;
      prev_ok_q  <= 1'b0;
      start_q    <= '0;
      trig_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      p_q        <= p_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      rd_idx_q   <= rd_idx_d;
      prev_q     <= prev_d;
      prev_ok_q  <= prev_ok_d;
      start_q    <= start_d;
      trig_q     <= trig_d;
      cfg_err_q  <= cfg_err_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  always_ff @(posedge sclk) begin
    if (wr_en) mem[wr_ptr_q] <= s;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_accept) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign busy      = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
  assign done      = (state_q == S_DONE) || (state_q == S_READ);
  assign triggered = trig_q;
  assign cfg_err   = cfg_err_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Bench for adc_trigger_capture: table of acquisitions plus abort/reset sequences,
// readout checked through a scoreboard queue of expected window samples.
module tb_adc_trigger_capture;
  localparam int AW = 4;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        din_valid, arm, abort, force_trig, trig_edge, rd_req;
  logic [15:0] trig_level;
  logic [AW:0] pre_len, post_len;
  logic        busy, triggered, done, cfg_err, rd_valid, rd_last;
  logic [15:0] rd_data;

  always #5 sclk = ~sclk;

  adc_trigger_capture #(.AW(AW), .OFFSET_BIN(1'b1)) dut (
    .sclk(sclk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .arm(arm),
    .abort(abort), .force_trig(force_trig), .trig_level(trig_level),
    .trig_edge(trig_edge), .pre_len(pre_len), .post_len(post_len),
    .busy(busy), .triggered(triggered), .done(done), .cfg_err(cfg_err),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last)
  );

  // kind 0: s = base + k, kind 1: fixed list, kind 2: s = base - k
  typedef struct {
    int p; int q; bit edge_f; int level; int kind; int base; int force_at; int trig; bit err;
  } vec_t;
  typedef struct { logic [15:0] d; logic last; } rd_exp_t;

  vec_t        tbl[8];
  rd_exp_t     sbq[$];
  rd_exp_t     mon_e;
  int          n_vec = 0;
  int          n_miss = 0;
  int          list2[6] = '{200, 150, 120, 110, 90, 80};
  logic [15:0] win[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [15:0] samp(input int kind, input int base, input int k);
    if (kind == 0) return 16'(base + k);
    if (kind == 1) return (k < 6) ? 16'(list2[k]) : 16'h0;
    return 16'(base - k);
  endfunction

  always @(negedge sclk) begin
    if (rst_n && rd_valid) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_rd_valid: got rd_data %0h, required no rd_valid", rd_data);
      end else begin
        mon_e = sbq.pop_front();
        chk("rd_data", 32'(rd_data), 32'(mon_e.d));
        chk("rd_last", 32'(rd_last), 32'(mon_e.last));
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic do_arm(input int p, input int q, input bit e, input int lvl);
    pre_len    = (AW+1)'(p);
    post_len   = (AW+1)'(q);
    trig_edge  = e;
    trig_level = 16'(lvl);
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  task automatic feed(input vec_t v, input int n);
    for (int k = 0; k < n; k++) begin
      din_valid  = 1'b1;
      din        = samp(v.kind, v.base, k) ^ 16'h8000;
      force_trig = (k == v.force_at);
      tick();
    end
    din_valid  = 1'b0;
    force_trig = 1'b0;
  endtask

  // n_reads < 0 reads the whole window and checks the return to IDLE
  task automatic run_vec(input vec_t v, input int n_reads);
    int n, len, nr;
    do_arm(v.p, v.q, v.edge_f, v.level);
    chk("cfg_err", 32'(cfg_err), 32'(v.err));
    chk("busy_after_arm", 32'(busy), v.err ? 0 : 1);
    if (v.err) return;
    n = v.trig + v.q;
    feed(v, n - 1);
    chk("done_before_last", 32'(done), 0);
    feed(v, 0);
    din_valid  = 1'b1;
    din        = samp(v.kind, v.base, n - 1) ^ 16'h8000;
    force_trig = (n - 1 == v.force_at);
    tick();
    din_valid  = 1'b0;
    force_trig = 1'b0;
    chk("done", 32'(done), 1);
    chk("triggered", 32'(triggered), 1);
    chk("busy_done", 32'(busy), 0);
    for (int j = 0; j < 2; j++) begin
      din_valid = 1'b1;
      din       = 16'h5A5A;
      tick();
    end
    din_valid = 1'b0;
    len = v.p + v.q;
    for (int i = 0; i < len; i++) win[i] = samp(v.kind, v.base, v.trig - v.p + i);
    nr = (n_reads < 0) ? len : n_reads;
    for (int i = 0; i < nr; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rd_req = 1'b0;
        tick();
      end
      rd_req = 1'b1;
      sbq.push_back('{win[i], (i == len - 1)});
      tick();
    end
    if (n_reads < 0) begin
      tick();
      tick();
      rd_req = 1'b0;
      chk("done_after_read", 32'(done), 0);
      chk("busy_after_read", 32'(busy), 0);
      chk("sbq_empty", 32'(sbq.size()), 0);
    end
  endtask

  initial begin
    tbl[0] = '{4, 4, 1'b0, 0, 0, -8, -1, 8, 1'b0};
    tbl[1] = '{3, 2, 1'b1, 100, 1, 0, -1, 4, 1'b0};
    tbl[2] = '{0, 2, 1'b0, 90, 0, 100, 3, 3, 1'b0};
    tbl[3] = '{10, 7, 1'b0, 0, 0, 0, -1, 0, 1'b1};
    tbl[4] = '{0, 0, 1'b0, 0, 0, 0, -1, 0, 1'b1};
    tbl[5] = '{0, 1, 1'b0, 0, 0, 1234, 0, 0, 1'b0};
    tbl[6] = '{5, 11, 1'b0, 0, 0, 1000, 45, 45, 1'b0};
    tbl[7] = '{6, 10, 1'b1, 0, 2, 20, -1, 21, 1'b0};

    rst_n = 1'b0; din = '0; din_valid = 0; arm = 0; abort = 0; force_trig = 0;
    trig_edge = 0; trig_level = '0; pre_len = '0; post_len = '0; rd_req = 0;
    #12;
    chk("reset_flags", 32'({busy, triggered, done, cfg_err, rd_valid, rd_last}), 0);
    chk("reset_rd_data", 32'(rd_data), 0);
    @(negedge sclk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], -1);

    // abort in POST
    do_arm(2, 5, 1'b0, 0);
    feed('{2, 5, 1'b0, 0, 0, 50, 3, 3, 1'b0}, 5);
    chk("post_busy", 32'(busy), 1);
    chk("post_triggered", 32'(triggered), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_flags", 32'({busy, done, triggered}), 0);
    rd_req = 1'b1;
    tick();
    tick();
    rd_req = 1'b0;

    // cfg_err survives abort; abort beats a simultaneous arm
    do_arm(10, 7, 1'b0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("cfg_err_kept", 32'(cfg_err), 1);
    pre_len = 5'd2; post_len = 5'd2; arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    chk("arm_abort_busy", 32'(busy), 0);
    chk("arm_abort_cfg_err", 32'(cfg_err), 1);

    // abort in READ with a read in flight
    run_vec(tbl[0], 3);
    abort = 1'b1;
    rd_req = 1'b1;
    tick();
    abort = 1'b0;
    rd_req = 1'b0;
    chk("abort_read_flags", 32'({done, rd_valid, triggered}), 0);
    chk("abort_read_sbq", 32'(sbq.size()), 0);
    sbq.delete();

    // reset during READ, then a full re-acquisition
    run_vec(tbl[7], 2);
    rd_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_read_flags", 32'({busy, triggered, done, cfg_err, rd_valid, rd_last}), 0);
    chk("rst_read_rd_data", 32'(rd_data), 0);
    sbq.delete();
    @(negedge sclk);
    rst_n = 1'b1;
    rd_req = 1'b1;
    tick();
    tick();
    rd_req = 1'b0;
    chk("rst_read_done", 32'(done), 0);
    run_vec(tbl[0], -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
